mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the memory data width.
REQ-003 Parameter MAX_LOCK, default 8, SHALL set the maximum consecutive locked grants while the other master waits.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 mN_req  input  1  master N (N=0,1) requests one access this cycle.
REQ-008 mN_wr  input  1  master N access is a write (1) or read (0).
REQ-009 mN_lock  input  1  master N asks to keep ownership for its next request.
REQ-010 mN_addr  input  ADDR_WIDTH  master N address.
REQ-011 mN_wdata  input  DATA_WIDTH  master N write data, signed.
REQ-012 mN_gnt  output  1  master N access is performed this cycle.
REQ-013 mN_rvalid  output  1  master N read data is valid this cycle.
REQ-014 mN_rdata  output  DATA_WIDTH  master N read data, signed.
REQ-015 mem_wr  output  1  write strobe to data memory.
REQ-016 mem_addr  output  ADDR_WIDTH  address to data memory.
REQ-017 mem_wdata  output  DATA_WIDTH  write data to data memory.
REQ-018 mem_rdata  input  DATA_WIDTH  combinational read data from data memory.

Function
REQ-019 The FSM SHALL have states IDLE, OWN0 and OWN1; OWNn means master n won the previous cycle with mn_lock=1.
REQ-020 mN_gnt SHALL be combinational from the current state, requests, last-grant pointer and lock counter; at most one gnt is high per cycle.
REQ-021 In IDLE: a single requester SHALL be granted; on contention, the master not granted last SHALL be granted (round robin).
REQ-022 In OWNn: if mn_req=1, master n SHALL be granted regardless of the other request, unless the lock counter equals MAX_LOCK and the other master requests; then the other master SHALL be granted.
REQ-023 In OWNn with mn_req=0, arbitration SHALL proceed as in IDLE.
REQ-024 After a grant to master n, the next state SHALL be OWNn if mn_lock=1, else IDLE; with no grant, the next state SHALL be IDLE.
REQ-025 The lock counter SHALL increment on each grant to the owner while the other master requests, saturate at MAX_LOCK, and clear on any ownership change or on a return to IDLE.
REQ-026 The last-grant pointer SHALL update on every grant.
REQ-027 mem_addr, mem_wdata and mem_wr SHALL come from the granted master in the same cycle; with no grant, mem_wr=0 and mem_addr/mem_wdata SHALL hold the master0 values.
REQ-028 For a granted read, mem_rdata SHALL be registered into mN_rdata, and mN_rvalid SHALL pulse high one cycle after the grant for exactly one cycle.
REQ-029 mN_rdata SHALL hold its value until the next read completes for that master.
REQ-030 Writes SHALL never assert rvalid, and write latency SHALL be the grant cycle (data is written at the next edge).
REQ-031 Back-to-back reads by one master SHALL give rvalid on consecutive cycles with no bubble.

Reset
REQ-032 While rst_n=0, the state SHALL be IDLE, the pointer SHALL be "master1 last" (master0 wins the first contention), the lock counter SHALL be 0, mN_rvalid SHALL be 0 and mN_rdata SHALL be 0.
REQ-033 A reset during an outstanding read SHALL drop that rvalid, and no stale rvalid SHALL appear after release.
REQ-034 Because grants are combinational, mN_gnt and mem_wr SHALL be 0 while rst_n=0.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1) and the default MAX_LOCK constant.
REQ-036 One sub-module, mem_arb_rr, SHALL implement the 2-way round-robin pick (inputs: two requests and the pointer; outputs: one-hot grant).
REQ-037 mem_arbiter SHALL NOT contain the memory array; it connects to the existing data memory through the mem_* ports.

Verification
REQ-038 Reset then m0 read addr 0x05, memory holds 0x0000002A -> m0_gnt in the request cycle, m0_rvalid=1 with m0_rdata=0x2A on the next cycle.
REQ-039 m0 and m1 request continuously, no lock -> grants alternate m0, m1, m0, m1.
REQ-040 m1 writes 0xDEADBEEF to 0x10 while m0 reads 0x10 in the following cycle -> m0_rdata=0xDEADBEEF.
REQ-041 m0 holds lock and req for 20 cycles while m1 requests, MAX_LOCK=8 -> m0 gets 8 consecutive grants, then m1 is granted once, then m0 regains ownership.
REQ-042 Assert rst_n=0 in the cycle after a granted read -> no rvalid, rdata=0, state IDLE, and the first contention after release goes to m0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int MAX_LOCK_DEFAULT = 8;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: on contention the master that was not granted last wins.
module mem_arb_rr (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last1,
  output logic [1:0] o_gnt
);

  assign o_gnt[0] = i_req0 & (~i_req1 | i_last1);
  assign o_gnt[1] = i_req1 & (~i_req0 | ~i_last1);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port data memory with combinational read data.
// Grants are combinational; read data returns registered one cycle after the grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = MAX_LOCK_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m0_req,
  input  logic                         m0_wr,
  input  logic                         m0_lock,
  input  logic        [ADDR_WIDTH-1:0] m0_addr,
  input  logic signed [DATA_WIDTH-1:0] m0_wdata,
  output logic                         m0_gnt,
  output logic                         m0_rvalid,
  output logic signed [DATA_WIDTH-1:0] m0_rdata,
  input  logic                         m1_req,
  input  logic                         m1_wr,
  input  logic                         m1_lock,
  input  logic        [ADDR_WIDTH-1:0] m1_addr,
  input  logic signed [DATA_WIDTH-1:0] m1_wdata,
  output logic                         m1_gnt,
  output logic                         m1_rvalid,
  output logic signed [DATA_WIDTH-1:0] m1_rdata,
  output logic                         mem_wr,
  output logic        [ADDR_WIDTH-1:0] mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_wdata,
  input  logic signed [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_e                  r_state;
  logic                        r_last1;
  logic        [CW-1:0]        r_cnt;
  logic                        r_rvalid0;
  logic                        r_rvalid1;
  logic signed [DATA_WIDTH-1:0] r_rdata0;
  logic signed [DATA_WIDTH-1:0] r_rdata1;

  logic [1:0] w_rr_gnt;
  logic [1:0] w_gnt;
  logic       w_cnt_max;

  // First grant of a new ownership counts as one locked grant if the other master is waiting.
  function automatic logic [CW-1:0] f_lock_cnt(input logic i_same_owner,
                                               input logic i_other_req,
                                               input logic [CW-1:0] i_cnt);
    if (!i_same_owner) return i_other_req ? CW'(1) : '0;
    if (i_other_req && (i_cnt != CW'(MAX_LOCK))) return i_cnt + CW'(1);
    return i_cnt;
  endfunction

  mem_arb_rr u_rr (
    .i_req0 (m0_req),
    .i_req1 (m1_req),
    .i_last1(r_last1),
    .o_gnt  (w_rr_gnt)
  );

  assign w_cnt_max = (r_cnt == CW'(MAX_LOCK));

  always_comb begin
    w_gnt = 2'b00;
    case (r_state)
      OWN0: begin
        if (m0_req) w_gnt = (w_cnt_max && m1_req) ? 2'b10 : 2'b01;
        else        w_gnt = w_rr_gnt;
      end
      OWN1: begin
        if (m1_req) w_gnt = (w_cnt_max && m0_req) ? 2'b01 : 2'b10;
        else        w_gnt = w_rr_gnt;
      end
      default: w_gnt = w_rr_gnt;
    endcase
    if (!rst_n) w_gnt = 2'b00;
  end

  assign m0_gnt    = w_gnt[0];
  assign m1_gnt    = w_gnt[1];
  assign mem_wr    = (w_gnt[0] & m0_wr) | (w_gnt[1] & m1_wr);
  assign mem_addr  = w_gnt[1] ? m1_addr  : m0_addr;
  assign mem_wdata = w_gnt[1] ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last1   <= 1'b1;
      r_cnt     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt[0] & ~m0_wr;
      r_rvalid1 <= w_gnt[1] & ~m1_wr;
      if (w_gnt[0] && !m0_wr) r_rdata0 <= mem_rdata;
      if (w_gnt[1] && !m1_wr) r_rdata1 <= mem_rdata;

      if (w_gnt[0]) begin
        r_last1 <= 1'b0;
        if (m0_lock) begin
          r_state <= OWN0;
          r_cnt   <= f_lock_cnt(r_state == OWN0, m1_req, r_cnt);
        end else begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      end else if (w_gnt[1]) begin
        r_last1 <= 1'b1;
        if (m1_lock) begin
          r_state <= OWN1;
          r_cnt   <= f_lock_cnt(r_state == OWN1, m0_req, r_cnt);
        end else begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      end else begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end
    end
  end

  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural data memory (combinational read, clocked write).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
  logic        [7:0]  m0_addr, m1_addr;
  logic signed [31:0] m0_wdata, m1_wdata;
  logic               m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic signed [31:0] m0_rdata, m1_rdata;
  logic               mem_wr;
  logic        [7:0]  mem_addr;
  logic signed [31:0] mem_wdata, mem_rdata;

  logic signed [31:0] mem [256];
  logic               pre_we;
  logic        [7:0]  pre_addr;
  logic signed [31:0] pre_data;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0, input logic [7:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic l1,
                       input logic [7:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_wr = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wr = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  initial begin
    logic e0;
    logic p0, p1;
    drive(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0);
    pre_we = 1'b0; pre_addr = 8'h00; pre_data = 32'h0;

    // Reset: requests present, nothing granted, outputs cleared; preload memory meanwhile.
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 8'h05; pre_data = 32'h0000002A;
    drive(1, 1, 0, 8'h05, 32'h11, 1, 1, 0, 8'h10, 32'h22);
    #1;
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_rvalid0", m0_rvalid, 0);
    chk("rst_rvalid1", m1_rvalid, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_rdata1", m1_rdata, 0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));

    // Single read by m0 from 0x05.
    @(negedge clk);
    pre_we = 1'b0; rst_n = 1'b1;
    drive(1, 0, 0, 8'h05, 32'h0, 0, 0, 0, 8'h00, 32'h0);
    #1;
    chk("rd_gnt0", m0_gnt, 1);
    chk("rd_gnt1", m1_gnt, 0);
    chk("rd_mem_addr", mem_addr, 8'h05);
    chk("rd_mem_wr", mem_wr, 0);

    @(negedge clk);
    drive(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0);
    #1;
    chk("rd_rvalid0", m0_rvalid, 1);
    chk("rd_rdata0", m0_rdata, 32'h0000002A);
    chk("rd_rvalid1", m1_rvalid, 0);

    // m1 writes DEADBEEF to 0x10; rvalid0 must drop and rdata0 hold.
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 32'h0, 1, 1, 0, 8'h10, 32'hDEADBEEF);
    #1;
    chk("wr_rvalid0_drop", m0_rvalid, 0);
    chk("wr_rdata0_hold", m0_rdata, 32'h0000002A);
    chk("wr_gnt1", m1_gnt, 1);
    chk("wr_gnt0", m0_gnt, 0);
    chk("wr_mem_wr", mem_wr, 1);
    chk("wr_mem_addr", mem_addr, 8'h10);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);

    // m0 reads the freshly written location.
    @(negedge clk);
    drive(1, 0, 0, 8'h10, 32'h0, 0, 0, 0, 8'h00, 32'h0);
    #1;
    chk("raw_gnt0", m0_gnt, 1);
    chk("wr_no_rvalid1", m1_rvalid, 0);

    // m1 reads 0x10 alone so that m1 becomes the last-granted master.
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 32'h0, 1, 0, 0, 8'h10, 32'h0);
    #1;
    chk("raw_rvalid0", m0_rvalid, 1);
    chk("raw_rdata0", m0_rdata, 32'hDEADBEEF);
    chk("m1rd_gnt1", m1_gnt, 1);

    // Both request without lock: m0, m1, m0, m1.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, 0, 8'h05, 32'h0, 1, 0, 0, 8'h10, 32'h0);
      #1;
      chk($sformatf("rr_gnt0_%0d", i), m0_gnt, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_gnt1_%0d", i), m1_gnt, (i % 2 == 1) ? 1 : 0);
      if (i == 0) begin
        chk("m1rd_rvalid1", m1_rvalid, 1);
        chk("m1rd_rdata1", m1_rdata, 32'hDEADBEEF);
      end
    end

    // No grant: memory bus shows master0 fields with the write strobe low.
    @(negedge clk);
    drive(0, 0, 0, 8'h33, 32'h0, 0, 1, 0, 8'h44, 32'h55);
    #1;
    chk("idle_gnt0", m0_gnt, 0);
    chk("idle_gnt1", m1_gnt, 0);
    chk("idle_mem_wr", mem_wr, 0);
    chk("idle_mem_addr", mem_addr, 8'h33);
    chk("idle_rvalid1", m1_rvalid, 1);

    // m0 locks while m1 waits: 8 m0 grants, one m1 grant, repeating with period 9.
    p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1, 0, 1, 8'h05, 32'h0, 1, 0, 0, 8'h10, 32'h0);
      #1;
      e0 = (i % 9 != 8);
      chk($sformatf("lock_gnt0_%0d", i), m0_gnt, e0);
      chk($sformatf("lock_gnt1_%0d", i), m1_gnt, !e0);
      chk($sformatf("lock_rvalid0_%0d", i), m0_rvalid, p0);
      chk($sformatf("lock_rvalid1_%0d", i), m1_rvalid, p1);
      p0 = e0; p1 = !e0;
    end

    // Reset one cycle after a granted read: rvalid is dropped and data cleared.
    @(negedge clk);
    drive(1, 0, 1, 8'h05, 32'h0, 0, 0, 0, 8'h00, 32'h0);
    #1;
    chk("rstrd_gnt0", m0_gnt, 1);

    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0);
    #1;
    chk("rstrd_rvalid0", m0_rvalid, 0);
    chk("rstrd_rdata0", m0_rdata, 0);
    chk("rstrd_state", 32'(dut.r_state), 32'(IDLE));

    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 8'h05, 32'h0, 1, 0, 0, 8'h10, 32'h0);
    #1;
    chk("post_rst_gnt0", m0_gnt, 1);
    chk("post_rst_gnt1", m1_gnt, 0);
    chk("post_rst_rvalid0", m0_rvalid, 0);
    chk("post_rst_rvalid1", m1_rvalid, 0);

    @(negedge clk);
    drive(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0);
    #1;
    chk("post_rst_rd_rvalid0", m0_rvalid, 1);
    chk("post_rst_rd_rdata0", m0_rdata, 32'h0000002A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
